mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic. It sits directly upstream of the register file write port.
//  It captures memory-stage results and aligns and sign-extends load data.
//  It selects the writeback source (ALU, load, or link address).
//  It drives reg_write, rd and write_data into the decode-stage register file, and counts retired instructions.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_wb_stage_load_align.sv | 38 +++
 rtl/mem_wb_stage.sv | 110 +++++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline encodings: writeback source select and load size.
// Pure type/constant package; no logic, no latency, no flow control.
package mips_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_t;

    // Encoding 11 is treated as a word access.
    typedef enum logic [1:0] {
        LD_WORD   = 2'b00,
        LD_HALF   = 2'b01,
        LD_BYTE   = 2'b10,
        LD_WORD_X = 2'b11
    } ld_size_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load lane select with sign/zero extension for word, half and byte loads.
// Purely combinational (zero latency); no flow control.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  ld_size_t          size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Lane 0 is the most significant byte; a half ignores the low offset bit.
    always_comb begin
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];
        case (off)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
    end

    always_comb begin
        ext_data = rdata;
        case (size)
            LD_HALF: ext_data = {{(DATA_W-16){~is_unsigned & half_sel[15]}}, half_sel};
            LD_BYTE: ext_data = {{(DATA_W-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB register bank, writeback source mux and retire counter; one cycle m_* to outputs.
// No handshake: stall holds the bank, flush inserts a bubble and wins over stall.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_reg_write,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [1:0]        m_wb_sel,
    input  logic [1:0]        m_load_size,
    input  logic              m_load_unsigned,
    input  logic [DATA_W-1:0] m_alu_result,
    input  logic [DATA_W-1:0] m_mem_rdata,
    input  logic [DATA_W-1:0] m_pc_plus8,
    output logic              wb_valid,
    output logic              reg_write,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              valid_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] rd_q;
    wb_sel_t           wb_sel_q;
    ld_size_t          size_q;
    logic              unsigned_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] pc8_q;
    logic [CNT_W-1:0]  retire_q;
    logic [DATA_W-1:0] load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= WB_SEL_ALU;
            size_q      <= LD_WORD;
            unsigned_q  <= 1'b0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc8_q       <= '0;
            retire_q    <= '0;
        end else begin
            // The outgoing instruction retires unless it is being held; a flush
            // combined with a stall discards it instead.
            if (valid_q && !stall) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                rd_q        <= '0;
                wb_sel_q    <= WB_SEL_ALU;
                size_q      <= LD_WORD;
                unsigned_q  <= 1'b0;
                alu_q       <= '0;
                rdata_q     <= '0;
                pc8_q       <= '0;
            end else if (!stall) begin
                valid_q     <= m_valid;
                reg_write_q <= m_reg_write;
                rd_q        <= m_rd;
                wb_sel_q    <= wb_sel_t'(m_wb_sel);
                size_q      <= ld_size_t'(m_load_size);
                unsigned_q  <= m_load_unsigned;
                alu_q       <= m_alu_result;
                rdata_q     <= m_mem_rdata;
                pc8_q       <= m_pc_plus8;
            end
        end
    end

    load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .rdata      (rdata_q),
        .off        (alu_q[1:0]),
        .size       (size_q),
        .is_unsigned(unsigned_q),
        .ext_data   (load_data)
    );

    always_comb begin
        write_data = '0;
        case (wb_sel_q)
            WB_SEL_ALU:  write_data = alu_q;
            WB_SEL_MEM:  write_data = load_data;
            WB_SEL_LINK: write_data = pc8_q;
            default:     write_data = '0;
        endcase
    end

    // A stalled instruction keeps its write enable; rewriting the same value is harmless.
    assign reg_write    = valid_q & reg_write_q & (rd_q != '0) & (wb_sel_q != WB_SEL_RSVD);
    assign wb_valid     = valid_q;
    assign rd           = rd_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench: driver pushes model expectations, monitor compares after every edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_reg_write = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_wb_sel = '0;
    logic [1:0]  m_load_size = '0;
    logic        m_load_unsigned = 1'b0;
    logic [31:0] m_alu_result = '0;
    logic [31:0] m_mem_rdata = '0;
    logic [31:0] m_pc_plus8 = '0;
    logic        wb_valid, reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data, retire_count;
    logic        wb_valid_w, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] write_data_w;
    logic [3:0]  retire_count_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
        .m_wb_sel(m_wb_sel), .m_load_size(m_load_size),
        .m_load_unsigned(m_load_unsigned), .m_alu_result(m_alu_result),
        .m_mem_rdata(m_mem_rdata), .m_pc_plus8(m_pc_plus8),
        .wb_valid(wb_valid), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .retire_count(retire_count)
    );

    // Narrow counter copy so counter wrap-around is exercised many times.
    mem_wb_stage #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
        .m_wb_sel(m_wb_sel), .m_load_size(m_load_size),
        .m_load_unsigned(m_load_unsigned), .m_alu_result(m_alu_result),
        .m_mem_rdata(m_mem_rdata), .m_pc_plus8(m_pc_plus8),
        .wb_valid(wb_valid_w), .reg_write(reg_write_w), .rd(rd_w),
        .write_data(write_data_w), .retire_count(retire_count_w)
    );

    typedef struct {
        bit        vld, rw, uns;
        bit [4:0]  rd;
        bit [1:0]  sel, sz;
        bit [31:0] alu, rdata, pc8;
    } ent_t;

    typedef struct {
        bit        vld, rw;
        bit [4:0]  rd;
        bit [31:0] wd;
        longint    cnt;
    } exp_t;

    ent_t   cur;
    longint cnt;
    exp_t   sb[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] load_val(ent_t e);
        int        off;
        bit [31:0] v;
        off = int'(e.alu[1:0]);
        case (e.sz)
            2'd1: begin
                v = (e.rdata >> (16 * (1 - off / 2))) & 32'hFFFF;
                if (!e.uns && v[15]) v = v | 32'hFFFF_0000;
            end
            2'd2: begin
                v = (e.rdata >> (8 * (3 - off))) & 32'hFF;
                if (!e.uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            default: v = e.rdata;
        endcase
        return v;
    endfunction

    function automatic exp_t expect_of(ent_t e, longint c);
        exp_t x;
        x.vld = e.vld;
        x.rd  = e.rd;
        x.rw  = e.vld && e.rw && (e.rd != 0) && (e.sel != 2'd3);
        case (e.sel)
            2'd0:    x.wd = e.alu;
            2'd1:    x.wd = load_val(e);
            2'd2:    x.wd = e.pc8;
            default: x.wd = 32'h0;
        endcase
        x.cnt = c;
        return x;
    endfunction

    function automatic ent_t mk(bit vld, bit rw, bit [4:0] rdi, bit [1:0] sel, bit [1:0] sz,
                                bit uns, bit [31:0] alu, bit [31:0] rdata, bit [31:0] pc8);
        ent_t e;
        e.vld = vld; e.rw = rw; e.rd = rdi; e.sel = sel; e.sz = sz; e.uns = uns;
        e.alu = alu; e.rdata = rdata; e.pc8 = pc8;
        return e;
    endfunction

    function automatic ent_t rnd();
        return mk($urandom_range(3) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
                  2'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    endfunction

    // One clock of stimulus; the model decides what the stage holds and how many retired.
    task automatic drive(ent_t in, bit st, bit fl);
        @(negedge clk);
        rst = 1'b0;
        m_valid = in.vld; m_reg_write = in.rw; m_rd = in.rd; m_wb_sel = in.sel;
        m_load_size = in.sz; m_load_unsigned = in.uns; m_alu_result = in.alu;
        m_mem_rdata = in.rdata; m_pc_plus8 = in.pc8; stall = st; flush = fl;
        if (cur.vld && !st) cnt++;
        if (fl) cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (!st) cur = in;
        sb.push_back(expect_of(cur, cnt));
    endtask

    task automatic drive_chk(string name, ent_t in, bit st, bit fl,
                             bit [31:0] exp_wd, bit exp_rw, bit exp_vld);
        drive(in, st, fl);
        @(posedge clk);
        #2;
        chk({name, ".write_data"}, write_data, exp_wd);
        chk({name, ".reg_write"}, {31'b0, reg_write}, {31'b0, exp_rw});
        chk({name, ".wb_valid"}, {31'b0, wb_valid}, {31'b0, exp_vld});
    endtask

    task automatic check_zero(string name);
        chk({name, ".wb_valid"}, {31'b0, wb_valid}, 32'h0);
        chk({name, ".reg_write"}, {31'b0, reg_write}, 32'h0);
        chk({name, ".rd"}, {27'b0, rd}, 32'h0);
        chk({name, ".write_data"}, write_data, 32'h0);
        chk({name, ".retire_count"}, retire_count, 32'h0);
        chk({name, ".retire_count_w"}, {28'b0, retire_count_w}, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb.wb_valid", {31'b0, wb_valid}, {31'b0, e.vld});
                chk("sb.reg_write", {31'b0, reg_write}, {31'b0, e.rw});
                chk("sb.rd", {27'b0, rd}, {27'b0, e.rd});
                chk("sb.write_data", write_data, e.wd);
                chk("sb.retire_count", retire_count, 32'(e.cnt));
                chk("sb.retire_wrap", {28'b0, retire_count_w}, {28'b0, 4'(e.cnt % 16)});
                chk("sb.wrap_data", write_data_w, e.wd);
            end
        end
    end

    localparam logic [31:0] LD_WORD_VAL = 32'h80FF_7F01;

    initial begin : stim
        ent_t idle;
        ent_t jal;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        jal  = mk(1, 1, 5'd31, 2'd2, 2'd0, 0, 32'h0000_0103, 32'hDEAD_BEEF, 32'h0040_0008);
        cur  = idle;
        cnt  = 0;

        #1;
        check_zero("reset");
        drive(idle, 0, 0);

        drive_chk("alu", mk(1, 1, 5'd5, 2'd0, 2'd0, 0, 32'h0000_1234, $urandom, $urandom),
                  0, 0, 32'h0000_1234, 1, 1);
        chk("alu.rd", {27'b0, rd}, 32'd5);
        chk("alu.count_before", retire_count, 32'd0);
        drive_chk("lb_off1", mk(1, 1, 5'd6, 2'd1, 2'd2, 0, 32'h1001, LD_WORD_VAL, 0),
                  0, 0, 32'hFFFF_FFFF, 1, 1);
        chk("alu.count_after", retire_count, 32'd1);
        drive_chk("lbu_off0", mk(1, 1, 5'd7, 2'd1, 2'd2, 1, 32'h1000, LD_WORD_VAL, 0),
                  0, 0, 32'h0000_0080, 1, 1);
        drive_chk("lh_off2", mk(1, 1, 5'd8, 2'd1, 2'd1, 0, 32'h1002, LD_WORD_VAL, 0),
                  0, 0, 32'h0000_7F01, 1, 1);
        drive_chk("lh_off0", mk(1, 1, 5'd9, 2'd1, 2'd1, 0, 32'h1000, LD_WORD_VAL, 0),
                  0, 0, 32'hFFFF_80FF, 1, 1);
        drive_chk("lw", mk(1, 1, 5'd10, 2'd1, 2'd0, 0, 32'h1003, LD_WORD_VAL, 0),
                  0, 0, 32'h80FF_7F01, 1, 1);
        drive_chk("rd_zero", mk(1, 1, 5'd0, 2'd0, 2'd0, 0, 32'h55, 0, 0), 0, 0, 32'h55, 0, 1);
        drive_chk("rsvd", mk(1, 1, 5'd4, 2'd3, 2'd0, 0, 32'h77, 0, 32'h99), 0, 0, 32'h0, 0, 1);

        drive_chk("jal", jal, 0, 0, 32'h0040_0008, 1, 1);
        chk("jal.rd", {27'b0, rd}, 32'd31);
        for (int i = 0; i < 3; i++) begin
            drive_chk("stall", rnd(), 1, 0, 32'h0040_0008, 1, 1);
        end
        drive_chk("flush_stall", rnd(), 1, 1, 32'h0, 0, 0);
        drive(jal, 0, 0);
        drive_chk("flush", rnd(), 0, 1, 32'h0, 0, 0);

        drive(jal, 0, 0);
        drive(rnd(), 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        cur = idle;
        cnt = 0;
        drive(idle, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            drive(rnd(), $urandom_range(4) == 0, $urandom_range(9) == 0);
        end
        drive(idle, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb.drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
